// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit that owns the architectural HI/LO registers.
// Latency: mult/multu commit HI/LO MULT_CYCLES edges after accept, div/divu after DIV_CYCLES edges; mthi/mtlo commit at the accept edge.
// Backpressure: busy is high while an op is in flight; start is ignored while busy; cancel squashes only the op being offered.
// Ports: clk, reset (async active-low), start/op/a/b (offered op and operands), cancel (squash the offered op),
//        busy (mult/div in flight), hi/lo (architectural registers, driven directly from flops).
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic        cancel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    phi_q, phi_d;
   logic [31:0]    plo_q, plo_d;
   logic           wr_q, wr_d;      // pending result commits at completion (clear for divide by zero)
   logic [31:0]    hi_q, hi_d;
   logic [31:0]    lo_q, lo_d;

   // Arithmetic datapath, evaluated from the operands offered this cycle.
   logic [63:0]        mul_s, mul_u;
   logic               div_zero, div_ovf;
   logic [31:0]        dvs;
   logic signed [31:0] sq_raw, sr_raw;
   logic [31:0]        sq, sr, uq, ur;
   logic               accept;

   assign mul_s    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign mul_u    = {32'd0, a} * {32'd0, b};
   assign div_zero = (b == 32'd0);
   // The one signed quotient that does not fit: pin it rather than rely on tool behaviour.
   assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   // Divisor substitute keeps the divider defined on b == 0; that result is never committed.
   assign dvs      = div_zero ? 32'd1 : b;
   // Kept in separate signed assignments so the division stays signed.
   assign sq_raw   = $signed(a) / $signed(dvs);
   assign sr_raw   = $signed(a) % $signed(dvs);
   assign sq       = div_ovf ? 32'h8000_0000 : sq_raw;
   assign sr       = div_ovf ? 32'd0 : sr_raw;
   assign uq       = a / dvs;
   assign ur       = a % dvs;

   assign accept   = start & ~cancel & (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      wr_d    = wr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op)
                  OP_MULT: begin
                     phi_d   = mul_s[63:32];
                     plo_d   = mul_s[31:0];
                     wr_d    = 1'b1;
                     cnt_d   = CW'(MULT_CYCLES - 1);
                     state_d = RUN;
                  end
                  OP_MULTU: begin
                     phi_d   = mul_u[63:32];
                     plo_d   = mul_u[31:0];
                     wr_d    = 1'b1;
                     cnt_d   = CW'(MULT_CYCLES - 1);
                     state_d = RUN;
                  end
                  OP_DIV: begin
                     phi_d   = sr;
                     plo_d   = sq;
                     wr_d    = ~div_zero;
                     cnt_d   = CW'(DIV_CYCLES - 1);
                     state_d = RUN;
                  end
                  OP_DIVU: begin
                     phi_d   = ur;
                     plo_d   = uq;
                     wr_d    = ~div_zero;
                     cnt_d   = CW'(DIV_CYCLES - 1);
                     state_d = RUN;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // start and cancel are deliberately not looked at here: the in-flight op is older.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if (wr_q) begin
                  hi_d = phi_q;
                  lo_d = plo_q;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
         wr_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         wr_q    <= wr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit holding the architectural HI/LO registers. It consumes operands and the decoded MDU operation from the execute-stage pipeline register and runs a fixed-latency multi-cycle operation. It raises `busy` so the hazard unit can freeze the decode→execute boundary. It accepts a cancel from the exception/interrupt logic, so an operation squashed by an exception never touches HI/LO.

## Interface
- `MULT_CYCLES`, default 5: cycles from accepted mult/multu to HI/LO update (≥1).
- `DIV_CYCLES`, default 10: cycles from accepted div/divu to HI/LO update (≥1).

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately.
- `start`  in  1: `op` is valid this cycle.
- `op`  in  3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved, treated as none.
- `cancel`  in  1: exception/interrupt taken this cycle; the instruction in execute is squashed.
- `a`  in  32: rs operand, forwarded.
- `b`  in  32: rt operand, forwarded.
- `busy`  out  1: a mult/div is in flight.
- `hi`  out  32: HI register, read by mfhi.
- `lo`  out  32: LO register, read by mflo.

## Operation
- States: IDLE, RUN. Down-counter `cnt` is as wide as needed for max(MULT_CYCLES, DIV_CYCLES). Pending result registers are `phi` and `plo`.
- **Accept condition:** `start & ~cancel & state==IDLE`. This is evaluated at a rising edge.
- **Mult/div accepted** (op 1–4):
  - The full result is computed from `a` and `b` and latched into `phi`/`plo`.
  - `cnt` loads the op's latency minus 1.
  - State goes to RUN.
- **mthi/mtlo accepted:**
  - `hi` (or `lo`) ← `a` at that edge. The other register is unchanged.
  - No busy; state stays IDLE.
- **RUN:**
  - While `cnt != 0`, each edge decrements `cnt`.
  - At the edge where `cnt == 0`: `hi` ← `phi`, `lo` ← `plo`, state goes to IDLE.
- `busy` = (state == RUN). It is registered, not a function of `start`. The hazard unit stalls on `busy | (start & op in 1..6 while busy)` externally.
- **Arithmetic:**
  - mult: signed 32×32 → 64. `hi` = [63:32], `lo` = [31:0].
  - multu: same, unsigned.
  - div: `lo` = quotient truncated toward zero, `hi` = remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
  - Signed 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0.
  - Divide by zero: the operation runs its full latency, busy behaves normally, and HI/LO are left unchanged at completion.
- **Boundary rules:**
  - `start` while RUN: ignored. This is a protocol violation that the stall logic prevents, and it must not corrupt the in-flight op.
  - `cancel` with `start` in the same cycle: the op is discarded, including mthi/mtlo.
  - `cancel` during RUN: ignored. The in-flight op belongs to an older instruction and completes normally.
  - `op` none/reserved with `start`: no effect.
  - **Reset low at any time:** `hi` = `lo` = 0, `busy` = 0, state IDLE, `cnt` = 0, `phi`/`plo` = 0. An in-flight op is lost.

## Timing
- Reset values: `busy` 0, `hi` 0x00000000, `lo` 0x00000000.
- Mult accepted at edge E0:
  - `busy` is 1 from just after E0 until edge E0+MULT_CYCLES, where it falls.
  - HI/LO take the new value at that same edge.
  - `busy` is high for exactly MULT_CYCLES cycles.
- Div: same pattern with DIV_CYCLES.
- A new `start` is accepted at the completion edge's successor: back-to-back ops with zero idle cycles beyond the busy window.
- mthi/mtlo: HI/LO update at the accept edge. A mfhi/mflo in the next cycle reads the new value.
- `hi`/`lo` are direct register outputs, so there is no combinational path from inputs.

## Test plan
- **mult:** mult a=0xFFFFFFFD (−3), b=5 → `busy` high 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; HI/LO unchanged during busy.
- **divu then div:**
  - divu a=100, b=7 → after 10 cycles `lo`=14, `hi`=2.
  - Immediately follow with div a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **Divide by zero:** mthi a=0x12345678, then div a=9, b=0 → `busy` 10 cycles; `hi` stays 0x12345678, `lo` stays 0.
- **Cancel on start:**
  - mult a=2, b=3 with `cancel`=1 → `busy` stays 0, HI/LO unchanged.
  - mtlo a=0xABCD with `cancel`=1 → `lo` unchanged.
- **Cancel and start during RUN:**
  - `cancel` pulse during mult RUN → mult completes with the correct result.
  - `start` with mthi during RUN → `hi` is not written by the mthi.
- **Reset mid-operation:** assert `reset` low asynchronously in the 3rd cycle of a div → `busy`, `hi`, `lo` are 0 immediately, before the next edge, and no update occurs after release.
